// File: rtl/serial_pkg.sv
// Shared serial definitions: UART FSM state encoding and 8N1 frame constants,
// common to the serial MMIO and the serial endpoint.
package serial_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int         FRAME_BITS = 8;
  localparam logic [2:0] LAST_BIT   = 3'(FRAME_BITS - 1);
  localparam logic       LINE_IDLE  = 1'b1;
  localparam logic       START_BIT  = 1'b0;
  localparam logic       STOP_BIT   = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; head is read combinationally from storage.
// Push when full is dropped even if a pop happens in the same cycle.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [FRAME_BITS-1:0] data_in,
  input  logic                  pop,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [FRAME_BITS-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign data_out = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is reset so the combinational head reads 0 after reset
  // rather than X; the array is tiny, so the reset cost is negligible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= data_in;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/serial_endpoint.sv
// UART endpoint bridging the processor serial MMIO to an 8N1 serial line,
// with TX/RX byte FIFOs and sticky overrun/framing error flags.
module serial_endpoint
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] cpu_data_in,
  input  logic                  cpu_wren_in,
  output logic                  cpu_ready_out,
  output logic [FRAME_BITS-1:0] cpu_data_out,
  output logic                  cpu_valid_out,
  input  logic                  cpu_rden_in,
  input  logic                  uart_rx_in,
  output logic                  uart_tx_out,
  output logic                  overrun_err_out,
  output logic                  framing_err_out
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------- TX path ----------------
  uart_state_e           tx_state, tx_state_nxt;
  logic [CNT_W-1:0]      tx_cnt, tx_cnt_nxt;
  logic [2:0]            tx_idx, tx_idx_nxt;
  logic [FRAME_BITS-1:0] tx_shift, tx_shift_nxt;
  logic [FRAME_BITS-1:0] tx_head;
  logic                  tx_full, tx_empty, tx_pop, tx_line;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (cpu_wren_in),
    .data_in  (cpu_data_in),
    .pop      (tx_pop),
    .data_out (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  assign cpu_ready_out = !tx_full;

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_idx_nxt   = tx_idx;
    tx_shift_nxt = tx_shift;
    tx_pop       = 1'b0;
    tx_line      = LINE_IDLE;
    case (tx_state)
      UART_IDLE: begin
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_shift_nxt = tx_head;
          tx_cnt_nxt   = '0;
          tx_state_nxt = UART_START;
        end
      end
      UART_START: begin
        tx_line = START_BIT;
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_idx_nxt   = '0;
          tx_state_nxt = UART_DATA;
        end else tx_cnt_nxt = tx_cnt + CNT_ONE;
      end
      UART_DATA: begin
        tx_line = tx_shift[0];
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_shift_nxt = tx_shift >> 1;
          if (tx_idx == LAST_BIT) tx_state_nxt = UART_STOP;
          else tx_idx_nxt = tx_idx + 3'd1;
        end else tx_cnt_nxt = tx_cnt + CNT_ONE;
      end
      UART_STOP: begin
        tx_line = STOP_BIT;
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nxt = '0;
          if (!tx_empty) begin
            tx_pop       = 1'b1;
            tx_shift_nxt = tx_head;
            tx_state_nxt = UART_START;
          end else tx_state_nxt = UART_IDLE;
        end else tx_cnt_nxt = tx_cnt + CNT_ONE;
      end
      default: tx_state_nxt = UART_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // The line is registered, so it trails the FSM state by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state    <= UART_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_shift    <= '0;
      uart_tx_out <= LINE_IDLE;
    end else begin
      tx_state    <= tx_state_nxt;
      tx_cnt      <= tx_cnt_nxt;
      tx_idx      <= tx_idx_nxt;
      tx_shift    <= tx_shift_nxt;
      uart_tx_out <= tx_line;
    end
  end

  // ---------------- RX path ----------------
  uart_state_e           rx_state, rx_state_nxt;
  logic [CNT_W-1:0]      rx_cnt, rx_cnt_nxt;
  logic [2:0]            rx_idx, rx_idx_nxt;
  logic [FRAME_BITS-1:0] rx_shift, rx_shift_nxt;
  logic [1:0]            rx_sync;
  logic                  rx_bit, rx_full, rx_empty, rx_push;
  logic                  overrun_set, framing_set;

  assign rx_bit = rx_sync[1];

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (rx_push),
    .data_in  (rx_shift),
    .pop      (cpu_rden_in),
    .data_out (cpu_data_out),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  assign cpu_valid_out = !rx_empty;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_idx_nxt   = rx_idx;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    overrun_set  = 1'b0;
    framing_set  = 1'b0;
    case (rx_state)
      UART_IDLE: begin
        if (rx_bit == START_BIT) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = UART_START;
        end
      end
      UART_START: begin
        // Half-bit resample: a start bit that has gone high again was a glitch.
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_nxt = '0;
          rx_idx_nxt = '0;
          rx_state_nxt = (rx_bit == START_BIT) ? UART_DATA : UART_IDLE;
        end else rx_cnt_nxt = rx_cnt + CNT_ONE;
      end
      UART_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_bit, rx_shift[FRAME_BITS-1:1]};
          if (rx_idx == LAST_BIT) rx_state_nxt = UART_STOP;
          else rx_idx_nxt = rx_idx + 3'd1;
        end else rx_cnt_nxt = rx_cnt + CNT_ONE;
      end
      UART_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = UART_IDLE;
          if (rx_bit == STOP_BIT) begin
            rx_push     = !rx_full;
            overrun_set = rx_full;
          end else framing_set = 1'b1;
        end else rx_cnt_nxt = rx_cnt + CNT_ONE;
      end
      default: rx_state_nxt = UART_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync         <= 2'b11;
      rx_state        <= UART_IDLE;
      rx_cnt          <= '0;
      rx_idx          <= '0;
      rx_shift        <= '0;
      overrun_err_out <= 1'b0;
      framing_err_out <= 1'b0;
    end else begin
      rx_sync         <= {rx_sync[0], uart_rx_in};
      rx_state        <= rx_state_nxt;
      rx_cnt          <= rx_cnt_nxt;
      rx_idx          <= rx_idx_nxt;
      rx_shift        <= rx_shift_nxt;
      overrun_err_out <= overrun_err_out | overrun_set;
      framing_err_out <= framing_err_out | framing_set;
    end
  end

endmodule

// File: doc/serial_endpoint.md
SERIAL_ENDPOINT -- requirements
Module: serial_endpoint

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (even, >=4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per byte FIFO (power of two, >=2).
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserting clears all state immediately.
REQ-005 cpu_data_in  in  8  byte from the processor-side serial MMIO (its serial_out).
REQ-006 cpu_wren_in  in  1  push cpu_data_in into the TX FIFO.
REQ-007 cpu_ready_out  out  1  TX FIFO not full; drives the MMIO serial_ready_in.
REQ-008 cpu_data_out  out  8  head of the RX FIFO; drives the MMIO serial_in.
REQ-009 cpu_valid_out  out  1  RX FIFO not empty; drives the MMIO serial_valid_in.
REQ-010 cpu_rden_in  in  1  pop the RX FIFO head.
REQ-011 uart_rx_in  in  1  external serial line, asynchronous, idle high.
REQ-012 uart_tx_out  out  1  external serial line, idle high.
REQ-013 overrun_err_out  out  1  sticky: RX byte dropped because the RX FIFO was full.
REQ-014 framing_err_out  out  1  sticky: RX stop bit sampled low.

Function
REQ-015 Frame format SHALL be 8N1: start 0, 8 data bits LSB first, stop 1, each bit held CLKS_PER_BIT cycles.
REQ-016 Both FIFOs SHALL be first-word-fall-through; head data is combinational from storage.
REQ-017 Push when full SHALL be ignored, even if a pop occurs in the same cycle; pop when empty SHALL be ignored.
REQ-018 Simultaneous push and pop on a non-full, non-empty FIFO SHALL both take effect; occupancy is unchanged.
REQ-019 TX FSM states: IDLE, START, DATA, STOP; IDLE with TX FIFO non-empty SHALL pop the head into a shift register and enter START.
REQ-020 A byte written at edge N into an empty TX FIFO while TX is IDLE SHALL drive uart_tx_out low from edge N+2.
REQ-021 START->DATA->STOP transitions SHALL follow a bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-022 At STOP end, a non-empty TX FIFO SHALL go directly to START with no idle cycles; otherwise IDLE.
REQ-023 uart_rx_in SHALL pass a two-flop synchronizer before use.
REQ-024 RX FSM states: IDLE, START, DATA, STOP; IDLE SHALL enter START on synchronized low.
REQ-025 START SHALL resample at CLKS_PER_BIT/2; high returns to IDLE with no error (glitch), low enters DATA.
REQ-026 DATA SHALL sample each bit CLKS_PER_BIT cycles after the previous sample (bit centre), shifting LSB first.
REQ-027 STOP sample high SHALL push the byte (or set overrun_err_out if full); low SHALL set framing_err_out and push nothing.
REQ-028 After a STOP sample, RX SHALL return to IDLE at once, so the next start edge is detected.
REQ-029 Sticky error flags SHALL clear only on reset.

Reset
REQ-030 Reset values: uart_tx_out=1, cpu_ready_out=1, cpu_valid_out=0, cpu_data_out=0, both error flags 0, both FSMs IDLE, FIFOs empty, synchronizer flops 1.
REQ-031 Reset mid-frame SHALL abort the frame; TX line returns high asynchronously; the partial RX byte is discarded.

Structure
REQ-032 UART state encodings and 8N1 frame constants SHALL live in the shared serial package used by the serial MMIO.
REQ-033 One sub-module, byte_fifo (parameter DEPTH), SHALL be instantiated twice (TX and RX).
REQ-034 Target size: 120-400 lines of RTL total.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-035 Reset released -> uart_tx_out=1, cpu_ready_out=1, cpu_valid_out=0, both error flags 0.
REQ-036 Write 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, 4 cycles each, start bit beginning 2 edges after write.
REQ-037 5 back-to-back writes 0x01..0x05 while TX idle -> first popped at once, remaining 4 fill FIFO, cpu_ready_out low, 5 frames with no gaps; extra 6th write while full dropped.
REQ-038 Drive RX frame 0x3C -> cpu_valid_out=1, cpu_data_out=0x3C; one cpu_rden_in -> cpu_valid_out=0.
REQ-039 Drive 5 RX frames without reads -> FIFO holds first 4 in order, overrun_err_out=1; 1-cycle low glitch -> no push, no error; stop bit 0 -> framing_err_out=1, no push.
REQ-040 Assert reset mid TX and mid RX frame -> uart_tx_out=1 immediately, FIFOs empty, no byte pushed after release.
